inject_arbiter: RTL
===================

INJECT_ARBITER -- requirements
Module: inject_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 2, number of injector sources (2..8).
REQ-002 SHALL have parameter FLIT_SIZE, default 32, flit width in bits.
REQ-003 SHALL have parameter BUFFER_DEPTH, default 4, output FIFO depth (power of two, >=2).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port src_rx_i  input  N_SRC  per-source flit valid.
REQ-007 SHALL have port src_credit_o  output  N_SRC  per-source credit (flit accepted when rx and credit both high).
REQ-008 SHALL have port src_data_i  input  N_SRC x FLIT_SIZE  per-source flit.
REQ-009 SHALL have port src_eoa_i  input  N_SRC  per-source end-of-application.
REQ-010 SHALL have port tx_o  output  1  output flit valid.
REQ-011 SHALL have port credit_i  input  1  downstream credit.
REQ-012 SHALL have port data_o  output  FLIT_SIZE  output flit.
REQ-013 SHALL have port eoa_o  output  1  all sources finished and arbiter drained.
REQ-014 SHALL have port grant_o  output  N_SRC  one-hot current owner (zero when idle), for debug.

Function
REQ-015 SHALL treat each packet as: header flit, size flit (value S), then S payload flits; S=0 ends packet after size flit.
REQ-016 SHALL implement FSM states IDLE, HEADER, SIZE, PAYLOAD.
REQ-017 SHALL in IDLE, when any src_rx_i high, grant round-robin: first requester at index above last winner, wrapping; transition to HEADER next cycle.
REQ-018 SHALL hold grant for the whole packet; no interleaving of flits from different sources.
REQ-019 SHALL drive src_credit_o high only for the granted source, only in HEADER/SIZE/PAYLOAD, and only when FIFO not full.
REQ-020 SHALL advance HEADER->SIZE and SIZE->PAYLOAD on each accepted flit; on accepting size flit load counter with S, or go IDLE if S=0.
REQ-021 SHALL decrement payload counter per accepted payload flit; on accepting the flit with counter=1 go IDLE, update last winner, clear grant.
REQ-022 SHALL use a FLIT_SIZE-bit payload counter; S up to 2^FLIT_SIZE-1 supported without wrap.
REQ-023 SHALL push every accepted flit into the output FIFO; tx_o = FIFO non-empty; data_o = FIFO head; pop when tx_o and credit_i.
REQ-024 SHALL present an accepted flit on data_o no earlier than the next cycle (minimum latency 1 cycle).
REQ-025 SHALL allow simultaneous push and pop when full (pop frees slot; credit computed from registered full flag only, so no push that cycle) and when empty (flit appears next cycle).
REQ-026 SHALL sustain one flit/cycle throughput while credit_i stays high and FIFO not full.
REQ-027 SHALL assert eoa_o when all src_eoa_i high, FSM in IDLE, and FIFO empty; deassert immediately otherwise.
REQ-028 SHALL ignore src_rx_i of non-granted sources (no credit, no data loss).

Reset
REQ-029 SHALL on rst_ni low: FSM IDLE, counter 0, last winner N_SRC-1 (so source 0 wins first), FIFO empty, tx_o 0, src_credit_o 0, grant_o 0, eoa_o 0.
REQ-030 SHALL on reset mid-packet discard FIFO contents and partial packet; no flit emitted after reset release until a new grant.

Structure
REQ-031 SHALL place packet-state enum and flit-offset constants (header=0, size=1) in the shared simulation package.
REQ-032 SHALL implement the output FIFO as sub-module inject_fifo (parameters FLIT_SIZE, BUFFER_DEPTH, full/empty flags).
REQ-033 SHALL contain no simulation-only constructs so it is synthesizable alongside the many-core.

Verification
REQ-034 Source 0 sends header 0x0101, size 2, payload 0xA, 0xB with credit_i always 1 -> data_o sequence 0x0101,2,0xA,0xB, one per cycle, grant_o=01 throughout.
REQ-035 Both sources request at same cycle after reset, each one packet size 1 -> source 0 packet complete first, then source 1; no interleaving.
REQ-036 Source 1 packet size 0 -> exactly 2 flits output, FSM back to IDLE after size flit.
REQ-037 credit_i held 0 with BUFFER_DEPTH=4, source streaming size 10 -> exactly 4 flits accepted, src_credit_o drops; release credit_i -> remaining flits delivered in order.
REQ-038 rst_ni pulsed low mid-payload -> tx_o 0 next cycle, FIFO empty, new packet from source 0 transfers correctly after release.
REQ-039 All src_eoa_i high while last packet still in FIFO -> eoa_o low until final flit popped, then high.

Source files
------------

// File: rtl/inject_arbiter_pkg.sv
// rtl/inject_arbiter_pkg.sv - shared packet-state and flit-offset definitions for the inject arbiter
package inject_arbiter_pkg;

    localparam int unsigned FLIT_OFS_HEADER = 0;
    localparam int unsigned FLIT_OFS_SIZE   = 1;

    // Header/size states sit one above the offset of the flit they wait for.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'(FLIT_OFS_HEADER + 1),
        ST_SIZE    = 2'(FLIT_OFS_SIZE + 1),
        ST_PAYLOAD = 2'd3
    } pkt_state_e;

endpackage

// File: rtl/inject_fifo.sv
// rtl/inject_fifo.sv - output flit FIFO with registered full/empty flags
module inject_fifo #(
    parameter int FLIT_SIZE    = 32,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [FLIT_SIZE-1:0] push_data_i,
    input  logic                 pop_i,
    output logic [FLIT_SIZE-1:0] pop_data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int AW = $clog2(BUFFER_DEPTH);

    logic [FLIT_SIZE-1:0] mem_q [BUFFER_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW:0]          count_q;
    logic [AW:0]          count_n;
    logic                 full_q;
    logic                 empty_q;
    logic                 do_push;
    logic                 do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        count_n = count_q;
        if (do_push && !do_pop) begin
            count_n = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_n = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_n;
            full_q  <= (count_n == (AW+1)'(BUFFER_DEPTH));
            empty_q <= (count_n == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/inject_arbiter.sv
// rtl/inject_arbiter.sv - round-robin packet arbiter merging injector sources into one flit stream
module inject_arbiter
    import inject_arbiter_pkg::*;
#(
    parameter int N_SRC        = 2,
    parameter int FLIT_SIZE    = 32,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [N_SRC-1:0]                  src_rx_i,
    output logic [N_SRC-1:0]                  src_credit_o,
    input  logic [N_SRC-1:0][FLIT_SIZE-1:0]   src_data_i,
    input  logic [N_SRC-1:0]                  src_eoa_i,
    output logic                              tx_o,
    input  logic                              credit_i,
    output logic [FLIT_SIZE-1:0]              data_o,
    output logic                              eoa_o,
    output logic [N_SRC-1:0]                  grant_o
);

    localparam int IDX_W = $clog2(N_SRC);

    pkt_state_e           state_q;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     last_q;
    logic [N_SRC-1:0]     grant_q;
    logic [FLIT_SIZE-1:0] count_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 accept;
    logic [FLIT_SIZE-1:0] in_flit;
    logic                 hi_found;
    logic                 lo_found;
    logic [IDX_W-1:0]     hi_idx;
    logic [IDX_W-1:0]     lo_idx;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;

    // Requesters above the last winner take priority over those at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_rx_i[i] && !hi_found && (i > int'(last_q))) begin
                hi_found = 1'b1;
                hi_idx   = IDX_W'(i);
            end
            if (src_rx_i[i] && !lo_found && (i <= int'(last_q))) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
            end
        end
    end

    assign pick_valid = hi_found || lo_found;
    assign pick_idx   = hi_found ? hi_idx : lo_idx;

    // Credit uses only the registered full flag, so a pop never opens a same-cycle push.
    assign src_credit_o = ((state_q != ST_IDLE) && !fifo_full) ? grant_q : '0;
    assign accept       = |(src_rx_i & src_credit_o);
    assign in_flit      = src_data_i[owner_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(N_SRC - 1);
            grant_q <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        grant_q <= N_SRC'(1) << pick_idx;
                        state_q <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (accept) begin
                        state_q <= ST_SIZE;
                    end
                end
                ST_SIZE: begin
                    if (accept) begin
                        if (in_flit == '0) begin
                            state_q <= ST_IDLE;
                            last_q  <= owner_q;
                            grant_q <= '0;
                        end else begin
                            count_q <= in_flit;
                            state_q <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        count_q <= count_q - FLIT_SIZE'(1);
                        if (count_q == FLIT_SIZE'(1)) begin
                            state_q <= ST_IDLE;
                            last_q  <= owner_q;
                            grant_q <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    inject_fifo #(
        .FLIT_SIZE    (FLIT_SIZE),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (accept),
        .push_data_i (in_flit),
        .pop_i       (credit_i),
        .pop_data_o  (data_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign tx_o    = !fifo_empty;
    assign grant_o = grant_q;
    assign eoa_o   = rst_ni && (&src_eoa_i) && (state_q == ST_IDLE) && fifo_empty;

endmodule
